// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, opcodes and field positions for the ALU sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LOAD_B,
    S_LOAD_A,
    S_EXEC
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  localparam int OP4_MSB = 15;
  localparam int OP4_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic        is_imm;
    logic [2:0]  alu_op;
    logic [15:0] imm16;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        illegal;
    logic        no_wb;
  } dec_t;

  // Register selects reserve 0 for "no register"
  function automatic logic [4:0] reg_sel(input logic [3:0] idx);
    return {1'b0, idx} + 5'd1;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - instruction handshake and datapath control bundle
interface alu_seq_if #(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 8
);
  logic [15:0]         inst;
  logic                inst_valid;
  logic                inst_ready;
  logic [15:0]         immediate;
  logic                imm_control;
  logic [4:0]          control1;
  logic [4:0]          control2;
  logic [OPW-1:0]      opcode;
  logic                buff_en;
  logic [NUM_REGS-1:0] enable;
  logic                inst_done;
  logic                illegal_op;

  modport master (
    output inst, inst_valid,
    input  inst_ready, immediate, imm_control, control1, control2,
           opcode, buff_en, enable, inst_done, illegal_op
  );

  modport slave (
    input  inst, inst_valid,
    output inst_ready, immediate, imm_control, control1, control2,
           opcode, buff_en, enable, inst_done, illegal_op
  );
endinterface

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational instruction decoder
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [15:0] i_inst,
  output dec_t        o_dec
);

  logic [3:0]  w_op4;
  logic [3:0]  w_ext;
  logic [7:0]  w_imm8;
  logic        w_rr;
  logic [2:0]  w_alu_op;
  logic        w_zext;
  logic [15:0] w_imm16;

  assign w_op4    = i_inst[OP4_MSB:OP4_LSB];
  assign w_ext    = i_inst[EXT_MSB:EXT_LSB];
  assign w_imm8   = i_inst[IMM_MSB:IMM_LSB];
  assign w_rr     = (w_op4 == 4'd0);
  assign w_alu_op = w_rr ? w_ext[2:0] : w_op4[2:0];

  // Logical ops take the byte as a mask; arithmetic ops treat it as signed
  assign w_zext  = (w_alu_op == OP_AND) || (w_alu_op == OP_OR) || (w_alu_op == OP_XOR);
  assign w_imm16 = w_zext ? {8'h00, w_imm8} : {{8{w_imm8[7]}}, w_imm8};

  assign o_dec = '{
    is_imm:  !w_rr,
    alu_op:  w_alu_op,
    imm16:   w_imm16,
    rd:      i_inst[RD_MSB:RD_LSB],
    rs:      i_inst[RS_MSB:RS_LSB],
    illegal: w_rr ? ((w_ext == 4'd0) || w_ext[3]) : w_op4[3],
    no_wb:   (w_alu_op == OP_CMP)
  };

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control sequencer in front of the ALU datapath
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  state_t              r_state;
  logic [15:0]         r_inst;
  logic                r_ready;
  logic [15:0]         r_imm;
  logic                r_imm_ctrl;
  logic [4:0]          r_ctrl1;
  logic [4:0]          r_ctrl2;
  logic [OPW-1:0]      r_opcode;
  logic                r_buff_en;
  logic [NUM_REGS-1:0] r_enable;
  logic                r_done;
  logic                r_illegal;

  logic [15:0] w_dec_inst;
  dec_t        w_dec;
  logic        w_accept;

  // Decode the incoming word while idle so DECODE-cycle outputs can be registered
  assign w_dec_inst = (r_state == S_IDLE) ? bus.inst : r_inst;
  assign w_accept   = (r_state == S_IDLE) && bus.inst_valid && r_ready;

  alu_seq_decode u_decode (
    .i_inst (w_dec_inst),
    .o_dec  (w_dec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_inst     <= '0;
      r_ready    <= 1'b0;
      r_imm      <= '0;
      r_imm_ctrl <= 1'b0;
      r_ctrl1    <= '0;
      r_ctrl2    <= '0;
      r_opcode   <= '0;
      r_buff_en  <= 1'b0;
      r_enable   <= '0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_ready    <= 1'b0;
      r_imm      <= '0;
      r_imm_ctrl <= 1'b0;
      r_ctrl1    <= '0;
      r_ctrl2    <= '0;
      r_opcode   <= '0;
      r_buff_en  <= 1'b0;
      r_enable   <= '0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_inst    <= bus.inst;
            r_illegal <= w_dec.illegal;
            r_state   <= S_DECODE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_dec.illegal) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_LOAD_B;
            if (w_dec.is_imm) begin
              r_imm_ctrl <= 1'b1;
              r_imm      <= w_dec.imm16;
            end else begin
              r_ctrl2 <= reg_sel(w_dec.rs);
            end
          end
        end
        S_LOAD_B: begin
          r_ctrl1 <= reg_sel(w_dec.rd);
          r_state <= S_LOAD_A;
        end
        S_LOAD_A: begin
          r_opcode <= OPW'(w_dec.alu_op);
          r_done   <= 1'b1;
          if (!w_dec.no_wb) begin
            r_buff_en <= 1'b1;
            r_enable  <= NUM_REGS'(1) << w_dec.rd;
          end
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.inst_ready  = r_ready;
  assign bus.immediate   = r_imm;
  assign bus.imm_control = r_imm_ctrl;
  assign bus.control1    = r_ctrl1;
  assign bus.control2    = r_ctrl2;
  assign bus.opcode      = r_opcode;
  assign bus.buff_en     = r_buff_en;
  assign bus.enable      = r_enable;
  assign bus.inst_done   = r_done;
  assign bus.illegal_op  = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

  typedef struct packed {
    logic        ready;
    logic [15:0] imm;
    logic        immc;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [7:0]  op;
    logic        buff;
    logic [15:0] en;
    logic        done;
    logic        ill;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  alu_seq_if #(.NUM_REGS(16), .OPW(8)) bus ();

  alu_sequencer #(.NUM_REGS(16), .OPW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  rec_t exp_q[$];
  rec_t cur      = '0;
  bit   model_on = 1'b0;

  // Expected per-cycle outputs for one accepted instruction, starting at DECODE
  task automatic plan(input logic [15:0] i);
    int   op4, rd, ext, rs, aluop;
    bit   rr, illegal;
    logic [7:0]  imm8;
    logic [15:0] immv;
    rec_t d, lb, la, ex;
    op4 = i[15:12]; rd = i[11:8]; ext = i[7:4]; rs = i[3:0]; imm8 = i[7:0];
    rr = (op4 == 0);
    illegal = (op4 > 7) || (rr && (ext == 0 || ext > 7));
    aluop = rr ? ext : op4;
    if (aluop == 3 || aluop == 4 || aluop == 5) immv = {8'h00, imm8};
    else immv = 16'($signed(imm8));
    d = '0; lb = '0; la = '0; ex = '0;
    d.ill = illegal;
    exp_q.push_back(d);
    if (!illegal) begin
      if (rr) lb.c2 = 5'(rs + 1);
      else begin lb.immc = 1'b1; lb.imm = immv; end
      la.c1 = 5'(rd + 1);
      ex.op = 8'(aluop);
      ex.done = 1'b1;
      if (aluop != 6) begin ex.buff = 1'b1; ex.en = 16'(1 << rd); end
      exp_q.push_back(lb);
      exp_q.push_back(la);
      exp_q.push_back(ex);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      cur = '0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (bus.inst_valid && cur.ready) begin
      plan(bus.inst);
      cur = exp_q.pop_front();
    end else begin
      cur = '0;
      cur.ready = 1'b1;
    end
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    rec_t got;
    if (model_on) begin
      got = '{bus.inst_ready, bus.immediate, bus.imm_control, bus.control1, bus.control2,
              bus.opcode, bus.buff_en, bus.enable, bus.inst_done, bus.illegal_op};
      n_cmp++;
      if (got !== cur) begin
        n_fail++;
        $display("FAIL model t=%0t: got rdy=%b imm=%h ic=%b c1=%0d c2=%0d op=%h be=%b en=%h dn=%b il=%b required rdy=%b imm=%h ic=%b c1=%0d c2=%0d op=%h be=%b en=%h dn=%b il=%b",
                 $time, got.ready, got.imm, got.immc, got.c1, got.c2, got.op, got.buff, got.en, got.done, got.ill,
                 cur.ready, cur.imm, cur.immc, cur.c1, cur.c2, cur.op, cur.buff, cur.en, cur.done, cur.ill);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Leaves the caller at the negedge inside the DECODE cycle
  task automatic send(input logic [15:0] i);
    for (int k = 0; k < 20 && bus.inst_ready !== 1'b1; k++) @(negedge clk);
    chk("ready_wait", 64'(bus.inst_ready), 64'd1);
    bus.inst = i;
    bus.inst_valid = 1'b1;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    bus.inst = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_inst();
    logic [15:0] v;
    int k;
    v = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k < 5) v[15:12] = 4'h0;
    else if (k < 9) v[15:12] = 4'($urandom_range(1, 7));
    return v;
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({bus.immediate, bus.imm_control, bus.control1, bus.control2, bus.opcode,
                bus.buff_en, bus.enable, bus.inst_done, bus.illegal_op});
  endfunction

  initial begin
    reset = 1'b0;
    bus.inst_valid = 1'b1;
    bus.inst = 16'h13FE;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.inst_ready), 64'd0);
    chk("rst_outs", all_out(), 64'd0);
    reset = 1'b1;
    bus.inst_valid = 1'b0;
    @(negedge clk);
    chk("rel_ready", 64'(bus.inst_ready), 64'd1);

    send(16'h13FE);
    chk("addi_dec_ill", 64'(bus.illegal_op), 64'd0);
    @(negedge clk);
    chk("addi_immc", 64'(bus.imm_control), 64'd1);
    chk("addi_imm", 64'(bus.immediate), 64'hFFFE);
    @(negedge clk);
    chk("addi_c1", 64'(bus.control1), 64'd4);
    @(negedge clk);
    chk("addi_op", 64'(bus.opcode), 64'h01);
    chk("addi_be", 64'(bus.buff_en), 64'd1);
    chk("addi_en", 64'(bus.enable), 64'h0008);
    chk("addi_done", 64'(bus.inst_done), 64'd1);
    @(negedge clk);
    chk("addi_ready", 64'(bus.inst_ready), 64'd1);

    send(16'h0255);
    @(negedge clk);
    chk("xor_c2", 64'(bus.control2), 64'd6);
    chk("xor_immc", 64'(bus.imm_control), 64'd0);
    @(negedge clk);
    chk("xor_c1", 64'(bus.control1), 64'd3);
    @(negedge clk);
    chk("xor_op", 64'(bus.opcode), 64'h05);
    chk("xor_en", 64'(bus.enable), 64'h0004);

    send(16'h30F0);
    @(negedge clk);
    chk("andi_imm", 64'(bus.immediate), 64'h00F0);

    send(16'h0A61);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("cmp_op", 64'(bus.opcode), 64'h06);
    chk("cmp_be", 64'(bus.buff_en), 64'd0);
    chk("cmp_en", 64'(bus.enable), 64'd0);

    send(16'h9000);
    chk("ill9_pulse", 64'(bus.illegal_op), 64'd1);
    @(negedge clk);
    chk("ill9_drop", 64'(bus.illegal_op), 64'd0);
    chk("ill9_ready", 64'(bus.inst_ready), 64'd1);
    send(16'h0100);
    chk("ill0_pulse", 64'(bus.illegal_op), 64'd1);
    @(negedge clk);
    chk("ill0_ready", 64'(bus.inst_ready), 64'd1);
    chk("ill0_c1", 64'(bus.control1), 64'd0);

    send(16'h13FE);
    bus.inst_valid = 1'b1;
    bus.inst = 16'h0255;
    @(negedge clk);
    chk("busy_ready", 64'(bus.inst_ready), 64'd0);
    @(negedge clk);
    chk("mid_c1", 64'(bus.control1), 64'd4);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", all_out(), 64'd0);
    chk("mid_rst_ready", 64'(bus.inst_ready), 64'd0);
    reset = 1'b1;
    bus.inst_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_done", 64'(bus.inst_done), 64'd0);
    end
    send(16'h0255);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_en", 64'(bus.enable), 64'h0004);
    chk("post_rst_done", 64'(bus.inst_done), 64'd1);

    repeat (1500) begin
      @(negedge clk);
      reset = ($urandom_range(0, 49) != 0);
      bus.inst_valid = ($urandom_range(0, 2) != 0);
      bus.inst = rand_inst();
    end
    reset = 1'b1;
    bus.inst_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
